// File: rtl/clm_inverter_pkg.sv
// Shared types for the redundant (CLM) GF(2^8) inverter.
//   d           : redundancy degree; operands are 8+d bits, randomness words d bits
//   state_t     : redundant operand, polynomial of degree <= 7+d
//   red_poly_t  : fresh randomness word used by one reduction
//   nm_matrix_t : extended reduction matrix, one (7+2d)-bit column per canonical output bit
//   prod_t      : un-reduced carry-less product, 15+2d bits
//   red_reduce  : reduction shared by square and red_mult
package clm_inverter_pkg;

   localparam int unsigned d      = 2;
   localparam int unsigned N_STEP = 7;

   typedef logic [7+d:0]    state_t;
   typedef logic [d-1:0]    red_poly_t;
   typedef logic [14+2*d:0] prod_t;
   typedef logic [6+2*d:0]  red_vec_t;
   typedef logic [7:0][6+2*d:0] nm_matrix_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} inv_state_t;

   localparam state_t RED_ONE = state_t'(1);

   // Fold the high product bits and the fresh word r back into 8+d bits.
   // r enters twice: once verbatim at x^8..x^(7+d), once through B_ext as
   // r*x^8 mod P, so it cancels in the canonical value but masks the result.
   function automatic state_t red_reduce(input prod_t p, input red_poly_t r,
                                         input nm_matrix_t B);
      red_vec_t   v;
      logic [7:0] t;
      v = {r, p[14+2*d:8+d]};
      for (int i = 0; i < 8; i++) t[i] = ^(v & B[i]);
      return p[7+d:0] ^ {r, t};
   endfunction

endpackage

// File: rtl/clm_inverter_red_mult.sv
// Redundant multiplier: carry-less product of two (8+d)-bit operands followed
// by the same randomized reduction as the squarer. Purely combinational.
//   a_i, b_i : redundant operands
//   r_i      : fresh randomness word
//   B_ext_i  : extended reduction matrix
//   p_o      : redundant a*b
module red_mult
   import clm_inverter_pkg::*;
(
   input  state_t     a_i,
   input  state_t     b_i,
   input  red_poly_t  r_i,
   input  nm_matrix_t B_ext_i,
   output state_t     p_o
);

   prod_t prod;

   always_comb begin
      prod = '0;
      for (int i = 0; i < 8 + d; i++)
         if (b_i[i]) prod = prod ^ (prod_t'(a_i) << i);
   end

   assign p_o = red_reduce(prod, r_i, B_ext_i);

endmodule

// File: rtl/clm_inverter_square.sv
// Redundant squarer: carry-less square of a (8+d)-bit operand followed by the
// randomized reduction. Purely combinational.
//   a_i     : redundant operand
//   r_i     : fresh randomness word
//   B_ext_i : extended reduction matrix
//   sq_o    : redundant a^2
module square
   import clm_inverter_pkg::*;
(
   input  state_t     a_i,
   input  red_poly_t  r_i,
   input  nm_matrix_t B_ext_i,
   output state_t     sq_o
);

   prod_t prod;

   // Squaring over GF(2) just spreads bit i to position 2i.
   always_comb begin
      prod = '0;
      for (int i = 0; i < 8 + d; i++) prod[2*i] = a_i[i];
   end

   assign sq_o = red_reduce(prod, r_i, B_ext_i);

endmodule

// File: rtl/clm_inverter.sv
// Sequential GF(2^8) inverter x -> x^254 on redundant operands. Seven
// square-and-multiply steps, one per cycle with valid randomness; values are
// never reduced to canonical 8-bit form inside the block.
//   clk_i, rst_i           : clock, synchronous active-high reset
//   B_ext_i                : extended reduction matrix (static)
//   in_valid_i/in_ready_o  : operand handshake, in_data_i operand
//   rnd_valid_i/rnd_ready_o: randomness handshake, r_sq_i / r_mul_i words
//   out_valid_o/out_ready_i: result handshake, out_data_o = redundant x^254
module clm_inverter
   import clm_inverter_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  nm_matrix_t B_ext_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  state_t     in_data_i,
   input  logic       rnd_valid_i,
   output logic       rnd_ready_o,
   input  red_poly_t  r_sq_i,
   input  red_poly_t  r_mul_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output state_t     out_data_o
);

   inv_state_t state_q, state_d;
   state_t     sq_q, sq_d, acc_q, acc_d;
   state_t     sq_nxt, mul_out;
   logic [2:0] cnt_q, cnt_d;
   logic       out_valid_q, out_valid_d;
   logic       load;

   square u_square (
      .a_i     (sq_q),
      .r_i     (r_sq_i),
      .B_ext_i (B_ext_i),
      .sq_o    (sq_nxt)
   );

   // Multiplier consumes the fresh square in the same cycle.
   red_mult u_red_mult (
      .a_i     (acc_q),
      .b_i     (sq_nxt),
      .r_i     (r_mul_i),
      .B_ext_i (B_ext_i),
      .p_o     (mul_out)
   );

   always_comb begin
      state_d     = state_q;
      sq_d        = sq_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      in_ready_o  = 1'b0;
      rnd_ready_o = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_o = 1'b1;
            load       = in_valid_i;
         end
         RUN: begin
            rnd_ready_o = 1'b1;
            // No randomness -> hold everything; words are never reused.
            if (rnd_valid_i) begin
               sq_d  = sq_nxt;
               acc_d = mul_out;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(N_STEP - 1)) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end
            end
         end
         DONE: begin
            in_ready_o = out_ready_i;
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
               load        = in_valid_i;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         sq_d    = in_data_i;
         acc_d   = RED_ONE;
         cnt_d   = '0;
         state_d = RUN;
      end

      if (rst_i) begin
         in_ready_o  = 1'b0;
         rnd_ready_o = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         sq_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sq_q        <= sq_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   // Accumulator is only exposed while a result is being offered.
   assign out_data_o  = out_valid_q ? acc_q : '0;

endmodule

// File: tb/tb_clm_inverter.sv
module tb_clm_inverter;
   import clm_inverter_pkg::*;

   logic       clk_i = 1'b0;
   logic       rst_i;
   nm_matrix_t B_ext_i;
   logic       in_valid_i, in_ready_o;
   state_t     in_data_i;
   logic       rnd_valid_i, rnd_ready_o;
   red_poly_t  r_sq_i, r_mul_i;
   logic       out_valid_o, out_ready_i;
   state_t     out_data_o;

   int checks = 0;
   int errors = 0;

   clm_inverter dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .B_ext_i     (B_ext_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .rnd_valid_i (rnd_valid_i),
      .rnd_ready_o (rnd_ready_o),
      .r_sq_i      (r_sq_i),
      .r_mul_i     (r_mul_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] clmul(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] p = '0;
      for (int i = 0; i < 16; i++) if (b[i]) p = p ^ ({16'b0, a} << i);
      return p;
   endfunction

   function automatic logic [7:0] modp(input logic [31:0] p);
      for (int i = 31; i >= 8; i--) if (p[i]) p = p ^ (32'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] gfmul(input logic [7:0] a, input logic [7:0] b);
      return modp(clmul({8'b0, a}, {8'b0, b}));
   endfunction

   // Redundant embedding: x plus a multiple of P(x).
   function automatic state_t emb(input logic [7:0] x, input red_poly_t m);
      logic [31:0] t;
      t = {24'b0, x} ^ clmul(16'(m), 16'h11B);
      return t[7+d:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk_i);
      #1;
   endtask

   task automatic accept(input logic [7:0] x, input bit redund);
      int guard;
      guard = 0;
      in_data_i  = emb(x, redund ? red_poly_t'($urandom) : '0);
      in_valid_i = 1'b1;
      while (!in_ready_o && guard < 50) begin step; guard++; end
      step;
      in_valid_i = 1'b0;
   endtask

   task automatic run_rnd(input int pct, input bit redund, output int hs, output int cyc);
      hs = 0; cyc = 0;
      while (!out_valid_o && cyc < 300) begin
         rnd_valid_i = ($urandom_range(99) < pct);
         r_sq_i      = redund ? red_poly_t'($urandom) : '0;
         r_mul_i     = redund ? red_poly_t'($urandom) : '0;
         if (rnd_valid_i && rnd_ready_o) hs++;
         step;
         cyc++;
      end
      rnd_valid_i = 1'b0;
      chk("out_valid_reached", 32'(out_valid_o), 1);
   endtask

   task automatic release_out;
      out_ready_i = 1'b1;
      step;
      out_ready_i = 1'b0;
   endtask

   task automatic do_op(input logic [7:0] x, input bit redund, input int pct,
                        output logic [7:0] dec, output int hs, output int cyc);
      accept(x, redund);
      run_rnd(pct, redund, hs, cyc);
      dec = modp(32'(out_data_o));
   endtask

   initial begin
      logic [7:0] dec;
      int         hs, cyc;
      state_t     held;
      logic [7:0] res;

      // Reduction matrix: column entry for each monomial of {r, prod_hi}.
      for (int k = 0; k < 7 + d; k++) begin
         res = modp(32'(1) << (8 + d + k));
         for (int i = 0; i < 8; i++) B_ext_i[i][k] = res[i];
      end
      for (int m = 0; m < d; m++) begin
         res = modp(32'(1) << (8 + m));
         for (int i = 0; i < 8; i++) B_ext_i[i][7+d+m] = res[i];
      end

      rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0; rnd_valid_i = 1'b0;
      r_sq_i = '0; r_mul_i = '0; out_ready_i = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready_o), 0);
      step;
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_in_ready_cycle", 32'(in_ready_o), 0);
      chk("rst_rnd_ready", 32'(rnd_ready_o), 0);
      chk("rst_out_data", 32'(out_data_o), 0);
      rst_i = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready_o), 1);
      chk("post_rst_out_data", 32'(out_data_o), 0);

      // 1. zero redundancy, full-rate randomness
      do_op(8'h53, 1'b0, 100, dec, hs, cyc);
      chk("t1_dec", 32'(dec), 32'hCA);
      chk("t1_latency", 32'(cyc), 7);
      chk("t1_handshakes", 32'(hs), 7);
      release_out;
      chk("t1_out_valid_clr", 32'(out_valid_o), 0);
      chk("t1_in_ready_idle", 32'(in_ready_o), 1);

      // 2. redundant operand and random masks
      for (int n = 0; n < 3; n++) begin
         do_op(8'h53, 1'b1, 100, dec, hs, cyc);
         chk("t2_dec", 32'(dec), 32'hCA);
         release_out;
      end

      // 3. boundaries and exhaustive sweep
      do_op(8'h00, 1'b1, 100, dec, hs, cyc);
      chk("t3_zero", 32'(dec), 32'h00);
      release_out;
      do_op(8'h01, 1'b1, 100, dec, hs, cyc);
      chk("t3_one", 32'(dec), 32'h01);
      release_out;
      for (int x = 0; x < 256; x++) begin
         do_op(8'(x), 1'b1, 100, dec, hs, cyc);
         if (x == 0) chk("t3_sweep_zero", 32'(dec), 0);
         else        chk("t3_sweep_inv", 32'(gfmul(8'(x), dec)), 1);
         release_out;
      end

      // 4. stalling randomness
      do_op(8'h53, 1'b1, 50, dec, hs, cyc);
      chk("t4_dec", 32'(dec), 32'hCA);
      chk("t4_handshakes", 32'(hs), 7);
      release_out;
      do_op(8'hFF, 1'b1, 50, dec, hs, cyc);
      chk("t4_dec_ff", 32'(dec), 32'h1C);
      chk("t4_handshakes_ff", 32'(hs), 7);
      release_out;

      // 5. backpressure then back-to-back load
      do_op(8'h05, 1'b1, 100, dec, hs, cyc);
      chk("t5_dec", 32'(dec), 32'h52);
      held = out_data_o;
      for (int n = 0; n < 10; n++) begin
         step;
         chk("t5_hold_data", 32'(out_data_o), 32'(held));
         chk("t5_hold_valid", 32'(out_valid_o), 1);
         chk("t5_hold_in_ready", 32'(in_ready_o), 0);
      end
      in_data_i = emb(8'h03, red_poly_t'($urandom));
      in_valid_i = 1'b1;
      out_ready_i = 1'b1;
      #1;
      chk("t5_b2b_in_ready", 32'(in_ready_o), 1);
      step;
      in_valid_i = 1'b0;
      out_ready_i = 1'b0;
      chk("t5_b2b_out_valid", 32'(out_valid_o), 0);
      chk("t5_b2b_run", 32'(rnd_ready_o), 1);
      run_rnd(100, 1'b1, hs, cyc);
      chk("t5_b2b_dec", 32'(modp(32'(out_data_o))), 32'hF6);
      chk("t5_b2b_latency", 32'(cyc), 7);
      release_out;

      // 6. reset mid-run
      accept(8'h53, 1'b1);
      rnd_valid_i = 1'b1;
      for (int n = 0; n < 3; n++) begin
         r_sq_i = red_poly_t'($urandom); r_mul_i = red_poly_t'($urandom);
         step;
      end
      rnd_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      chk("t6_rst_in_ready", 32'(in_ready_o), 0);
      chk("t6_rst_rnd_ready", 32'(rnd_ready_o), 0);
      step;
      rst_i = 1'b0;
      #1;
      chk("t6_out_valid", 32'(out_valid_o), 0);
      chk("t6_idle_in_ready", 32'(in_ready_o), 1);
      chk("t6_idle_rnd_ready", 32'(rnd_ready_o), 0);
      chk("t6_out_data", 32'(out_data_o), 0);
      do_op(8'h02, 1'b1, 100, dec, hs, cyc);
      chk("t6_dec", 32'(dec), 32'h8D);
      chk("t6_handshakes", 32'(hs), 7);
      release_out;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
